// File: rtl/shift_stage.sv
// Multi-cycle barrel-free shifter stage: one bit per cycle, with a valid/ready handshake on both sides.
// The working register doubles as the result; the N and Z flags are decoded from it.
module shift_stage #(
    parameter int NBITS = 32,
    parameter int SHW   = $clog2(NBITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] alu_y,
    input  logic [1:0]       op,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] result,
    output logic             n_flag,
    output logic             z_flag
);

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SRL  = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    typedef struct packed {
        logic [NBITS-1:0] work;
        logic [SHW-1:0]   cnt;
        logic [1:0]       op;
    } ctx_t;

    state_e state, state_d;
    ctx_t   ctx, ctx_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ctx   <= '0;
        end else begin
            state <= state_d;
            ctx   <= ctx_d;
        end
    end

    always_comb begin
        state_d = state;
        ctx_d   = ctx;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    ctx_d.work = alu_y;
                    ctx_d.op   = op;
                    if (op == OP_PASS || shamt == '0) begin
                        state_d = DONE;
                    end else begin
                        ctx_d.cnt = shamt;
                        state_d   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                case (ctx.op)
                    OP_SLL:  ctx_d.work = {ctx.work[NBITS-2:0], 1'b0};
                    OP_SRL:  ctx_d.work = {1'b0, ctx.work[NBITS-1:1]};
                    OP_SRA:  ctx_d.work = {ctx.work[NBITS-1], ctx.work[NBITS-1:1]};
                    default: ctx_d.work = ctx.work;
                endcase
                ctx_d.cnt = ctx.cnt - SHW'(1);
                // <= 1 also catches an (unreachable) zero count instead of wrapping
                if (ctx.cnt <= SHW'(1))
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = ctx.work;
    assign n_flag    = ctx.work[NBITS-1];
    assign z_flag    = (ctx.work == '0);

endmodule

// File: tb/tb_shift_stage.sv
// Randomized and directed checks of shift_stage against an arithmetic shift model,
// covering latency, flags, backpressure hold, input isolation and mid-operation reset.
module tb_shift_stage;

    localparam int NBITS = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] alu_y;
    logic [1:0]       op;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] result;
    logic             n_flag;
    logic             z_flag;

    int n_cmp = 0;
    int n_err = 0;

    shift_stage #(.NBITS(NBITS), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_y     (alu_y),
        .op        (op),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .n_flag    (n_flag),
        .z_flag    (z_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] y, input logic [1:0] o, input int s);
        case (o)
            2'b00:   return y;
            2'b01:   return y << s;
            2'b10:   return y >> s;
            default: return $unsigned($signed(y) >>> s);
        endcase
    endfunction

    // One full transaction: accept, wait for out_valid (bounded), hold under stall, hand off.
    task automatic do_op(input logic [31:0] y, input logic [1:0] o, input int s, input int stall);
        logic [31:0] exp;
        int exp_lat;
        int lat;
        exp     = model(y, o, s);
        exp_lat = (o == 2'b00 || s == 0) ? 1 : s + 1;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        alu_y    = y;
        op       = o;
        shamt    = SHW'(s);
        @(posedge clk);
        #1;
        lat = 1;
        while (!out_valid && lat < 100) begin
            in_valid = 1'($urandom);
            alu_y    = $urandom;
            op       = 2'($urandom);
            shamt    = SHW'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("result", result, exp);
        chk("n_flag", n_flag, exp[31]);
        chk("z_flag", z_flag, exp == 0);
        chk("in_ready_busy", in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            alu_y = $urandom;
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_result", result, exp);
            chk("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("handoff_valid", out_valid, 0);
        chk("handoff_in_ready", in_ready, 1);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_y     = '0;
        op        = '0;
        shamt     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_result", result, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_n_flag", n_flag, 0);
        chk("rst_z_flag", z_flag, 1);

        do_op(32'h8000_0000, 2'b00, 5, 0);
        do_op(32'h0000_00FF, 2'b01, 8, 0);
        do_op(32'hF000_0000, 2'b11, 4, 0);
        do_op(32'hF000_0000, 2'b10, 4, 0);
        do_op(32'h0000_0001, 2'b01, 31, 10);
        do_op(32'h0000_0001, 2'b10, 1, 0);
        do_op(32'h8000_0000, 2'b11, 31, 1);
        do_op(32'h7FFF_FFFF, 2'b11, 31, 0);
        do_op(32'hDEAD_BEEF, 2'b01, 0, 2);

        // Mid-operation reset during a 20-step shift
        @(negedge clk);
        in_valid = 1'b1;
        alu_y    = 32'hFFFF_FFFF;
        op       = 2'b01;
        shamt    = 5'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_z_flag", z_flag, 1);
        chk("abort_in_ready", in_ready, 1);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("abort_no_pulse", seen, 0);
        do_op(32'h0000_1234, 2'b00, 0, 0);

        for (int k = 0; k < 40; k++)
            do_op($urandom, 2'($urandom), $urandom_range(0, 31), $urandom_range(0, 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
